// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator sequencer.
//   state_t         : frame controller states
//   beats_per_frame : data beats streamed into the accumulator per frame
//   prime_cycles    : clock-enable cycles needed to fill the accumulator pipeline
package acc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRIME,
    STREAM,
    WAIT_DONE,
    OUTPUT
  } state_t;

  function automatic int beats_per_frame(input int m, input int temp);
    return m * temp;
  endfunction

  function automatic int prime_cycles(input int l);
    return l + 1;
  endfunction

endpackage

// File: rtl/accumulator_sequencer.sv
// Frame-level controller for one serial bucket accumulator.
// On an accepted start it clears the accumulator, primes it with zero data,
// streams M*TEMP valid input beats into it, waits (with a timeout) for its
// completion pulse, captures the bucket vector and offers it downstream.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start, abort  : frame request (IDLE only), synchronous abort (non-IDLE)
//   busy          : high in every state except IDLE
//   in_valid/in_ready/in_data        : feature input stream
//   acc_clr/acc_ce/acc_features      : accumulator control and data
//   acc_done/acc_out                 : accumulator completion and result
//   out_valid/out_ready/out_data     : result output stream
//   frame_done    : one-cycle pulse on the result handshake
//   error         : sticky timeout flag, cleared by an accepted start
//   frame_count   : accepted results, saturating
module accumulator_sequencer
  import acc_seq_pkg::*;
#(
  parameter int PRECISION       = 8,
  parameter int NUM_FEATURES    = 1,
  parameter int M               = 6,
  parameter int TEMP            = 2,
  parameter int INITIAL_LATENCY = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           abort,
  output logic                                           busy,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NUM_FEATURES-1:0][PRECISION-1:0]         in_data,
  output logic                                           acc_clr,
  output logic                                           acc_ce,
  output logic [NUM_FEATURES-1:0][PRECISION-1:0]         acc_features,
  input  logic                                           acc_done,
  input  logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]  acc_out,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]  out_data,
  output logic                                           frame_done,
  output logic                                           error,
  output logic [15:0]                                    frame_count
);

  localparam int BEATS   = beats_per_frame(M, TEMP);
  localparam int PRIMES  = prime_cycles(INITIAL_LATENCY);
  localparam int BEAT_W  = $clog2(BEATS + 1);
  localparam int PRIME_W = $clog2(INITIAL_LATENCY + 2);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIMES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [PRIME_W-1:0]   prime_cnt;
  logic [TO_W-1:0]      to_cnt;
  // Abort and timeout clear the accumulator in the first IDLE cycle after.
  logic                 clr_pending;
  logic                 start_ok;
  logic                 abort_hit;
  logic                 timeout_hit;
  logic                 capture;
  logic                 handshake;

  assign start_ok  = (state == IDLE) && start && !abort;
  assign abort_hit = (state != IDLE) && abort;

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    timeout_hit  = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    busy         = (state != IDLE);
    in_ready     = (state == STREAM);
    out_valid    = (state == OUTPUT);
    acc_ce       = 1'b0;
    acc_features = '0;

    // Abort wins over every same-cycle event in the non-IDLE states.
    if (abort_hit) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) state_nxt = CLEAR;
        end
        CLEAR: begin
          state_nxt = PRIME;
        end
        PRIME: begin
          if (prime_cnt == PRIME_LAST) state_nxt = STREAM;
        end
        STREAM: begin
          if (in_valid && beat_cnt == BEAT_LAST) state_nxt = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (acc_done) begin
            capture   = 1'b1;
            state_nxt = OUTPUT;
          end else if (to_cnt == TO_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = IDLE;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            handshake = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (state == PRIME) acc_ce = 1'b1;
    if (state == STREAM) begin
      acc_ce       = in_valid;
      acc_features = in_data;
    end
  end

  // Clearing on capture drops acc_done so it cannot be seen twice.
  assign acc_clr    = (state == CLEAR) || capture || clr_pending;
  assign frame_done = handshake;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      prime_cnt   <= '0;
      to_cnt      <= '0;
      clr_pending <= 1'b0;
      error       <= 1'b0;
      frame_count <= '0;
      // NOTE: the result register is reset as well, since out_data is a
      // visible output that must read zero after reset.
      out_data    <= '0;
    end else begin
      state       <= state_nxt;
      clr_pending <= abort_hit || timeout_hit;

      // Each counter only runs in its own state and restarts from zero on entry.
      prime_cnt <= (state == PRIME)     ? prime_cnt + PRIME_W'(1) : '0;
      beat_cnt  <= (state == STREAM)    ? beat_cnt + BEAT_W'(in_valid) : '0;
      to_cnt    <= (state == WAIT_DONE) ? to_cnt + TO_W'(1) : '0;

      if (start_ok)         error <= 1'b0;
      else if (timeout_hit) error <= 1'b1;

      if (capture) out_data <= acc_out;

      if (handshake && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer. A behavioural accumulator
// stub sits beside the DUT; expected results come from a reference that sums
// the accepted beats per bucket and saturates.
module tb_accumulator_sequencer;

  localparam int P     = 8;
  localparam int NF    = 1;
  localparam int MB    = 6;
  localparam int TP    = 2;
  localparam int LAT   = 4;
  localparam int TO    = 16;
  localparam int BEATS = MB * TP;
  localparam int PRIME = LAT + 1;
  localparam int OW    = NF * MB * P;
  localparam int SMAX  = (1 << P) - 1;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          start = 1'b0;
  logic                          abort = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          out_ready = 1'b0;
  logic [NF-1:0][P-1:0]          in_data = '0;
  logic [NF-1:0][P-1:0]          acc_features;
  logic [NF-1:0][MB-1:0][P-1:0]  acc_out;
  logic [NF-1:0][MB-1:0][P-1:0]  out_data;
  logic busy, in_ready, acc_clr, acc_ce, acc_done, out_valid, frame_done, error;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_count = '0;
  logic [NF*P-1:0] beats[$];
  bit start_noise = 1'b0;

  accumulator_sequencer #(
    .PRECISION(P), .NUM_FEATURES(NF), .M(MB), .TEMP(TP),
    .INITIAL_LATENCY(LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_clr(acc_clr), .acc_ce(acc_ce), .acc_features(acc_features),
    .acc_done(acc_done), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done), .error(error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // ---------------- accumulator stub ----------------
  logic [OW-1:0] stub_acc;
  int            stub_ce;
  logic          stub_done;
  bit            stub_mute = 1'b0;

  function automatic logic [OW-1:0] stub_add(input logic [OW-1:0] acc,
                                             input logic [NF*P-1:0] feat,
                                             input int beat);
    logic [OW-1:0] r;
    int s;
    int b;
    r = acc;
    b = beat % MB;
    for (int f = 0; f < NF; f++) begin
      s = int'(acc[(f*MB+b)*P +: P]) + int'(feat[f*P +: P]);
      r[(f*MB+b)*P +: P] = (s > SMAX) ? P'(SMAX) : P'(s);
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_acc  <= '0;
      stub_ce   <= 0;
      stub_done <= 1'b0;
    end else if (acc_clr) begin
      stub_acc  <= '0;
      stub_ce   <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (acc_ce) begin
        stub_ce <= stub_ce + 1;
        if (stub_ce >= PRIME) begin
          stub_acc <= stub_add(stub_acc, acc_features, stub_ce - PRIME);
          if (stub_ce - PRIME == BEATS - 1 && !stub_mute) stub_done <= 1'b1;
        end
      end
    end
  end

  assign acc_out  = stub_acc;
  assign acc_done = stub_done;

  // ---------------- reference and helpers ----------------
  function automatic logic [OW-1:0] ref_result();
    int sums[NF][MB];
    logic [OW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++)
      for (int b = 0; b < MB; b++) sums[f][b] = 0;
    foreach (beats[i])
      for (int f = 0; f < NF; f++) sums[f][i % MB] += int'(beats[i][f*P +: P]);
    for (int f = 0; f < NF; f++)
      for (int b = 0; b < MB; b++)
        r[(f*MB+b)*P +: P] = (sums[f][b] > SMAX) ? P'(SMAX) : P'(sums[f][b]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raise start for one cycle; returns in the cycle after start was sampled.
  task automatic do_start();
    beats.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_stream();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reach_stream", in_ready, 1);
  endtask

  // Offer n beats (val<0 means random data) with an optional forced stall
  // after beat stall_after and a valid probability of vprob percent.
  task automatic feed(input int n, input int val, input int stall_after,
                      input int stall_len, input int vprob);
    int got = 0;
    int stalled = 0;
    int budget = 400;
    while (got < n && budget > 0) begin
      if (in_ready) begin
        if (got == stall_after && stalled < stall_len) begin
          in_valid = 1'b0;
          stalled++;
        end else if ($urandom_range(99) >= vprob) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          for (int f = 0; f < NF; f++)
            in_data[f] = (val < 0) ? P'($urandom) : P'(val);
        end
        start = start_noise && got >= 2 && got < 8;
        #1;
        if (!in_valid) check("stall_ce", acc_ce, 0);
        else begin
          beats.push_back(in_data);
          got++;
        end
      end
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (got < n) check("feed_budget", got, n);
  endtask

  task automatic finish_frame(input int hold);
    int cnt = 0;
    bit ok = 1'b1;
    logic [OW-1:0] exp;
    logic [OW-1:0] held;
    exp = ref_result();
    while (!out_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("out_valid", out_valid, 1);
    check("out_data", out_data, exp);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      if (!out_valid || out_data !== held || frame_done) ok = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) check("hold_stable", ok, 1);
    out_ready = 1'b1;
    #1;
    check("frame_done", frame_done, 1);
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
    @(negedge clk);
    out_ready = 1'b0;
    check("frame_count", frame_count, exp_count);
    check("idle_after", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int cnt;
    bit saw;
    logic [OW-1:0] prev;

    repeat (2) @(negedge clk);
    check("rst_outputs", {busy, in_ready, acc_clr, acc_ce, out_valid, frame_done, error}, 0);
    check("rst_count", frame_count, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal frame, cycle-exact: start in cycle 0.
    out_ready = 1'b1;
    do_start();
    check("clr_c1", acc_clr, 1);
    check("busy_c1", busy, 1);
    ok = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (!(acc_ce && acc_features == '0 && !in_ready && !acc_clr)) ok = 1'b0;
    end
    check("prime_window", ok, 1);
    @(negedge clk);
    check("ready_c7", in_ready, 1);
    feed(BEATS, 10, -1, 0, 100);
    check("done_after_last", acc_done, 1);
    check("clr_on_done", acc_clr, 1);
    finish_frame(0);
    out_ready = 1'b0;

    // Input stall of 5 cycles after beat 3.
    do_start();
    wait_stream();
    feed(BEATS, 10, 3, 5, 100);
    finish_frame(0);

    // Saturation with 10 cycles of backpressure.
    do_start();
    wait_stream();
    feed(BEATS, 200, -1, 0, 100);
    finish_frame(10);

    // Timeout: accumulator never completes.
    stub_mute = 1'b1;
    do_start();
    wait_stream();
    feed(BEATS, -1, -1, 0, 100);
    cnt = 0;
    saw = 1'b0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (out_valid) saw = 1'b1;
    end
    check("timeout_cycles", cnt, TO);
    check("timeout_error", error, 1);
    check("timeout_clr", acc_clr, 1);
    check("timeout_no_valid", saw, 0);
    @(negedge clk);
    check("timeout_clr_once", acc_clr, 0);
    check("error_sticky", error, 1);
    stub_mute = 1'b0;
    do_start();
    check("error_cleared", error, 0);
    wait_stream();
    feed(BEATS, -1, -1, 0, 100);
    finish_frame(0);

    // Abort at beat 5, then a fresh frame.
    do_start();
    wait_stream();
    feed(5, 10, -1, 0, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_clr", acc_clr, 1);
    check("abort_idle", {busy, in_ready}, 0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || frame_done || busy) saw = 1'b1;
    end
    check("abort_quiet", saw, 0);
    check("abort_count", frame_count, exp_count);
    do_start();
    wait_stream();
    feed(BEATS, 10, -1, 0, 100);
    finish_frame(0);

    // Abort colliding with acc_done: no capture, out_data keeps old value.
    prev = out_data;
    do_start();
    wait_stream();
    feed(BEATS, -1, -1, 0, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_idle", {busy, out_valid}, 0);
    check("abort_done_data", out_data, prev);

    // Abort colliding with the output handshake.
    do_start();
    wait_stream();
    feed(BEATS, -1, -1, 0, 100);
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_out_valid", out_valid, 1);
    out_ready = 1'b1;
    abort = 1'b1;
    #1;
    check("abort_no_done", frame_done, 0);
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_out_idle", {busy, out_valid, acc_clr}, 3'b001);
    check("abort_out_count", frame_count, exp_count);
    check("abort_out_data", out_data, ref_result());

    // Start held high during STREAM is ignored.
    start_noise = 1'b1;
    do_start();
    wait_stream();
    feed(BEATS, -1, -1, 0, 100);
    start_noise = 1'b0;
    finish_frame(0);

    // Random frames with random stalls and backpressure.
    for (int k = 0; k < 4; k++) begin
      do_start();
      wait_stream();
      feed(BEATS, -1, -1, 0, 60);
      finish_frame($urandom_range(5));
    end

    // Reset in the middle of PRIME.
    do_start();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {busy, in_ready, acc_clr, acc_ce, out_valid, frame_done, error}, 0);
    check("midrst_count", frame_count, 0);
    check("midrst_data", out_data, 0);
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // frame_count saturation.
    force dut.frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    exp_count = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      do_start();
      wait_stream();
      feed(BEATS, -1, -1, 0, 100);
      finish_frame(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
